// File: rtl/hcf_pkg.sv
// rtl/hcf_pkg.sv - shared widths and FSM state encoding for the HCF arbiter slice
// Contents:
//   N_DEF, REQ_DEF, IDW_DEF  default operand width, requester count, ID width
//   state_t                  arbiter FSM states (IDLE / RUN / DONE)
package hcf_pkg;

  localparam int N_DEF   = 8;
  localparam int REQ_DEF = 4;
  localparam int IDW_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/hcf_iter_core.sv
// rtl/hcf_iter_core.sv - iterative subtract-based HCF engine, one step per clock
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load            capture a_in/b_in, clear iteration count and done
//   a_in, b_in      operands sampled on load
//   step            perform one compare/subtract step (ignored once done)
//   done            registered: result is final
//   result          registered HCF value, valid while done=1
//   iters           number of subtraction steps taken so far
module hcf_iter_core
  import hcf_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic         step,
  output logic         done,
  output logic [N-1:0] result,
  output logic [N-1:0] iters
);

  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] iters_q, iters_d;
  logic [N-1:0] result_q, result_d;
  logic         done_q, done_d;

  // Termination is decided on the step and latched into done_q, so the
  // caller sees a registered done one cycle after the final evaluation.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    iters_d  = iters_q;
    result_d = result_q;
    done_d   = done_q;
    if (load) begin
      a_d      = a_in;
      b_d      = b_in;
      iters_d  = '0;
      result_d = '0;
      done_d   = 1'b0;
    end else if (step && !done_q) begin
      if (a_q == '0) begin
        result_d = b_q;
        done_d   = 1'b1;
      end else if (b_q == '0) begin
        result_d = a_q;
        done_d   = 1'b1;
      end else if (a_q == b_q) begin
        result_d = a_q;
        done_d   = 1'b1;
      end else if (a_q > b_q) begin
        // Larger operand is always the minuend, so no underflow.
        a_d     = a_q - b_q;
        iters_d = iters_q + N'(1);
      end else begin
        b_d     = b_q - a_q;
        iters_d = iters_q + N'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      iters_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      iters_q  <= iters_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;
  assign iters  = iters_q;

endmodule

// File: rtl/hcf_arbiter.sv
// rtl/hcf_arbiter.sv - round-robin front-end sharing one HCF engine among REQ requesters
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid[REQ]        per-requester request valid
//   req_a/req_b[REQ*N]    operands; requester i uses slice [i*N +: N]
//   req_ready[REQ]        one-hot accept, combinational, only in IDLE
//   resp_valid            result valid (DONE state)
//   resp_ready            consumer accepts result
//   resp_id               requester served
//   resp_hcf, resp_iters  HCF result and subtraction count
//   busy                  high whenever the FSM is not IDLE
module hcf_arbiter
  import hcf_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int REQ = REQ_DEF,
  parameter int IDW = IDW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ-1:0]   req_valid,
  input  logic [REQ*N-1:0] req_a,
  input  logic [REQ*N-1:0] req_b,
  output logic [REQ-1:0]   req_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [IDW-1:0]   resp_id,
  output logic [N-1:0]     resp_hcf,
  output logic [N-1:0]     resp_iters,
  output logic             busy
);

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] cur_id_q, cur_id_d;
  logic           resp_valid_q, resp_valid_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  logic [N-1:0]   resp_hcf_q, resp_hcf_d;
  logic [N-1:0]   resp_iters_q, resp_iters_d;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic           accept;
  logic [N-1:0]   sel_a;
  logic [N-1:0]   sel_b;
  logic           core_done;
  logic [N-1:0]   core_result;
  logic [N-1:0]   core_iters;

  // Round-robin search starting just after the last served requester.
  // Scanning k=1..REQ visits every index exactly once, ending on ptr itself,
  // so a lone requester can be served back-to-back.
  always_comb begin
    int             idx;
    logic [IDW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    cand        = '0;
    for (int k = 1; k <= REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= REQ) idx = idx - REQ;
      cand = IDW'(idx);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  // grant_found already implies req_valid[grant_idx], so the handshake
  // reduces to "IDLE with a grant".
  assign accept = (state_q == ST_IDLE) && grant_found;
  assign sel_a  = req_a[grant_idx*N +: N];
  assign sel_b  = req_b[grant_idx*N +: N];

  hcf_iter_core #(
    .N (N)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .a_in   (sel_a),
    .b_in   (sel_b),
    .step   (state_q == ST_RUN),
    .done   (core_done),
    .result (core_result),
    .iters  (core_iters)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cur_id_d     = cur_id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_hcf_d   = resp_hcf_q;
    resp_iters_d = resp_iters_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_RUN;
          ptr_d    = grant_idx;
          cur_id_d = grant_idx;
        end
      end
      ST_RUN: begin
        // Output registers only change here, so they stay stable for the
        // whole DONE period regardless of backpressure.
        if (core_done) begin
          state_d      = ST_DONE;
          resp_valid_d = 1'b1;
          resp_id_d    = cur_id_q;
          resp_hcf_d   = core_result;
          resp_iters_d = core_iters;
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= IDW'(REQ - 1);
      cur_id_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_hcf_q   <= '0;
      resp_iters_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cur_id_q     <= cur_id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_hcf_q   <= resp_hcf_d;
      resp_iters_q <= resp_iters_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_hcf   = resp_hcf_q;
  assign resp_iters = resp_iters_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
